// File: rtl/regfile_op_sequencer.sv
// Micro-op sequencer in front of a small register file: turns MOV/LDI/INC/CMP ops
// into one-hot read/write enables and write data. All outputs come straight from flops.
module regfile_op_sequencer #(
  parameter int REG_COUNT = 11,
  parameter int REG_WIDTH = 12,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [1:0]           op_code,
  input  logic [IDX_W-1:0]     op_src,
  input  logic [IDX_W-1:0]     op_dst,
  input  logic [REG_WIDTH-1:0] op_imm,
  output logic [REG_COUNT-1:0] rf_read_en,
  output logic [REG_COUNT-1:0] rf_write_en,
  output logic [REG_WIDTH-1:0] rf_datain,
  input  logic [REG_WIDTH-1:0] rf_dataout,
  output logic                 done,
  output logic                 eq_flag,
  output logic                 err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CMP, S_WRITE, S_ERR} state_t;
  typedef enum logic [1:0] {OP_MOV = 2'b00, OP_LDI = 2'b01, OP_INC = 2'b10, OP_CMP = 2'b11} opcode_t;

  // Only the fields needed after the accept cycle are kept; src/imm are consumed on accept.
  typedef struct packed {
    logic [1:0]       code;
    logic [IDX_W-1:0] dst;
  } op_t;

  state_t              state;
  op_t                 op_q;
  logic [REG_WIDTH-1:0] hold;

  function automatic logic [REG_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < REG_COUNT; i++)
      if (int'(idx) == i) onehot[i] = 1'b1;
  endfunction

  function automatic logic bad_idx(input logic [IDX_W-1:0] idx);
    bad_idx = (int'(idx) >= REG_COUNT);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      hold        <= '0;
      eq_flag     <= 1'b0;
      op_ready    <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      rf_read_en  <= '0;
      rf_write_en <= '0;
      rf_datain   <= '0;
    end else begin
      // Pulses and enables default low; each transition sets what the next state shows.
      done        <= 1'b0;
      err         <= 1'b0;
      rf_read_en  <= '0;
      rf_write_en <= '0;
      rf_datain   <= '0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q.code <= op_code;
            op_q.dst  <= op_dst;
            op_ready  <= 1'b0;
            if (bad_idx(op_dst) || (op_code != OP_LDI && bad_idx(op_src))) begin
              state <= S_ERR;
              err   <= 1'b1;
              done  <= 1'b1;
            end else if (op_code == OP_LDI) begin
              state       <= S_WRITE;
              rf_write_en <= onehot(op_dst);
              rf_datain   <= op_imm;
              done        <= 1'b1;
            end else begin
              state      <= S_READ;
              rf_read_en <= onehot(op_src);
            end
          end
        end
        S_READ: begin
          hold <= rf_dataout;
          done <= 1'b1;
          if (op_q.code == OP_CMP) begin
            state      <= S_CMP;
            rf_read_en <= onehot(op_q.dst);
          end else begin
            // Write data is hold (MOV) or hold+1 (INC), taken from the value being latched.
            state       <= S_WRITE;
            rf_write_en <= onehot(op_q.dst);
            rf_datain   <= (op_q.code == OP_INC) ? rf_dataout + REG_WIDTH'(1) : rf_dataout;
          end
        end
        S_CMP: begin
          eq_flag  <= (rf_dataout == hold);
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        S_WRITE, S_ERR: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural register file attached.
module tb_regfile_op_sequencer;
  localparam int RC = 11, RW = 12, IW = 4;
  localparam logic [1:0] MOV = 2'b00, LDI = 2'b01, INC = 2'b10, CMP = 2'b11;

  logic          clk = 1'b0, reset = 1'b1, op_valid = 1'b0;
  logic [1:0]    op_code = '0;
  logic [IW-1:0] op_src = '0, op_dst = '0;
  logic [RW-1:0] op_imm = '0;
  logic          op_ready, done, eq_flag, err;
  logic [RC-1:0] rf_read_en, rf_write_en;
  logic [RW-1:0] rf_datain, rf_dataout;
  logic [RW-1:0] mem [RC] = '{default: '0};
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.REG_COUNT(RC), .REG_WIDTH(RW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_src(op_src), .op_dst(op_dst), .op_imm(op_imm), .rf_read_en(rf_read_en),
    .rf_write_en(rf_write_en), .rf_datain(rf_datain), .rf_dataout(rf_dataout),
    .done(done), .eq_flag(eq_flag), .err(err)
  );

  always_comb begin
    rf_dataout = '0;
    for (int i = 0; i < RC; i++) if (rf_read_en[i]) rf_dataout = mem[i];
  end

  always @(posedge clk)
    for (int i = 0; i < RC; i++) if (rf_write_en[i]) mem[i] <= rf_datain;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents an op in IDLE; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] c, input int s, input int d, input int imm);
    op_valid = 1'b1; op_code = c; op_src = IW'(s); op_dst = IW'(d); op_imm = RW'(imm);
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    // 1: reset and LDI
    tick(); reset = 1'b0;
    chk("rst_ready", op_ready, 1); chk("rst_rd", rf_read_en, 0); chk("rst_wr", rf_write_en, 0);
    chk("rst_din", rf_datain, 0); chk("rst_eq", eq_flag, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    issue(LDI, 0, 2, 'h5A3);
    chk("ldi_wr", rf_write_en, 11'b00000000100); chk("ldi_din", rf_datain, 'h5A3);
    chk("ldi_done", done, 1); chk("ldi_ready", op_ready, 0); chk("ldi_rd", rf_read_en, 0);
    tick(); chk("ldi_back", op_ready, 1); chk("ldi_done_end", done, 0);

    // 2: MOV 2 -> 7
    issue(MOV, 2, 7, 0);
    chk("mov_rd", rf_read_en, 'h004); chk("mov_ready0", op_ready, 0); chk("mov_done0", done, 0);
    tick();
    chk("mov_wr", rf_write_en, 'h080); chk("mov_din", rf_datain, 'h5A3);
    chk("mov_done", done, 1); chk("mov_ready1", op_ready, 0); chk("mov_rd_off", rf_read_en, 0);
    tick(); chk("mov_back", op_ready, 1); chk("mov_file", mem[7], 'h5A3);

    // 3: INC wrap in place
    issue(LDI, 0, 4, 'hFFF); tick();
    issue(INC, 4, 4, 0);
    chk("inc_rd", rf_read_en, 'h010);
    tick();
    chk("inc_din", rf_datain, 'h000); chk("inc_wr", rf_write_en, 'h010); chk("inc_err", err, 0);
    tick(); chk("inc_file", mem[4], 0);

    // 4: CMP equal then unequal
    issue(LDI, 0, 1, 'h010); tick();
    issue(LDI, 0, 3, 'h010); tick();
    issue(CMP, 1, 3, 0);
    chk("cmp_rd_src", rf_read_en, 'h002);
    tick();
    chk("cmp_rd_dst", rf_read_en, 'h008); chk("cmp_done", done, 1); chk("cmp_wr", rf_write_en, 0);
    tick(); chk("cmp_eq1", eq_flag, 1); chk("cmp_back", op_ready, 1);
    issue(LDI, 0, 3, 'h011); tick();
    issue(CMP, 1, 3, 0); tick(); tick();
    chk("cmp_eq0", eq_flag, 0);
    issue(CMP, 2, 7, 0); tick(); tick();
    chk("cmp_eq_again", eq_flag, 1);

    // 5: out-of-range index
    issue(MOV, 12, 0, 0);
    chk("err_err", err, 1); chk("err_done", done, 1); chk("err_rd", rf_read_en, 0);
    chk("err_wr", rf_write_en, 0); chk("err_ready0", op_ready, 0);
    tick();
    chk("err_ready1", op_ready, 1); chk("err_pulse", err, 0); chk("err_eq", eq_flag, 1);
    issue(LDI, 15, 10, 'h123);
    chk("ldi_src_ignored", err, 0); chk("ldi_r10", rf_write_en, 'h400);
    tick();
    issue(CMP, 0, 11, 0);
    chk("err_dst11", err, 1); chk("err_dst11_rd", rf_read_en, 0);
    tick();

    // 6: reset during READ
    issue(INC, 4, 4, 0);
    chk("rst_mid_rd", rf_read_en, 'h010);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_wr", rf_write_en, 0); chk("rst_mid_ready", op_ready, 1); chk("rst_mid_done", done, 0);
    chk("rst_mid_din", rf_datain, 0); chk("rst_mid_eq", eq_flag, 0);
    tick(); chk("rst_mid_wr2", rf_write_en, 0); chk("rst_mid_file", mem[4], 0);

    // random run: enables zero or one-hot every cycle
    for (int n = 0; n < 1000; n++) begin
      int waited;
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
            int'($urandom_range(0, 4095)));
      waited = 0;
      while (!op_ready && waited < 5) begin
        chk("rnd_rd_onehot", $onehot0(rf_read_en), 1);
        chk("rnd_wr_onehot", $onehot0(rf_write_en), 1);
        tick(); waited++;
      end
      chk("rnd_ready", op_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
